// File: rtl/protobuf_pkg.sv
// Shared constants and types for the protobuf deserializer.
//   - wire-type codes carried in key[2:0]
//   - out_kind encodings presented on the record stream
//   - FSM state enum (FIXED exists only with PROTOBUF_DESER_FIXED_EN)
//   - maximum encoded lengths of a key and of a value/length varint
package protobuf_pkg;

  localparam logic [2:0] WT_VARINT = 3'd0;
  localparam logic [2:0] WT_I64    = 3'd1;
  localparam logic [2:0] WT_LEN    = 3'd2;
  localparam logic [2:0] WT_I32    = 3'd5;

  localparam logic [2:0] KIND_VARINT  = 3'd0;
  localparam logic [2:0] KIND_I64     = 3'd1;
  localparam logic [2:0] KIND_LEN     = 3'd2;
  localparam logic [2:0] KIND_PAYLOAD = 3'd3;
  localparam logic [2:0] KIND_I32     = 3'd5;

  localparam logic [3:0] KEY_MAX_BYTES    = 4'd5;
  localparam logic [3:0] VARINT_MAX_BYTES = 4'd10;

  typedef enum logic [2:0] {
    KEY,
    VARINT,
`ifdef PROTOBUF_DESER_FIXED_EN
    FIXED,
`endif
    LEN,
    PAYLOAD,
    EMIT,
    ERROR
  } state_e;

endpackage

// File: rtl/protobuf_deserializer_if.sv
// Byte-stream in / record-stream out bundle of the protobuf deserializer.
//   in_data/in_valid/in_ready   : serialized bytes, transfer on valid&ready
//   out_valid/out_ready         : decoded record handshake
//   out_kind/field/value/len/last : record payload
// Modports: slave = the deserializer, master = the environment around it.
interface protobuf_deserializer_if #(
  parameter int FIELD_W = 29,
  parameter int LEN_W   = 16
);
  logic [7:0]         in_data;
  logic               in_valid;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic [2:0]         out_kind;
  logic [FIELD_W-1:0] out_field;
  logic [63:0]        out_value;
  logic [LEN_W-1:0]   out_len;
  logic               out_last;

  modport slave (
    input  in_data, in_valid, out_ready,
    output in_ready, out_valid, out_kind, out_field, out_value, out_len, out_last
  );

  modport master (
    output in_data, in_valid, out_ready,
    input  in_ready, out_valid, out_kind, out_field, out_value, out_len, out_last
  );
endinterface

// File: rtl/protobuf_varint_acc.sv
// Base-128 varint accumulator shared by key, value and length decoding.
//   clk, rst      : clock, async active-high reset
//   clr_i         : synchronous clear of accumulator and byte count
//   en_i, byte_i  : one encoded byte is consumed when en_i is high
//   max_bytes_i   : longest legal encoding for the current varint
//   val_o         : value including the current byte (valid with done_o)
//   done_o        : current byte terminates the varint (MSB clear)
//   overlong_o    : current byte is the last legal one yet still has MSB set
// The accumulator self-clears on done/overlong so the next varint starts clean.
module protobuf_varint_acc (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr_i,
  input  logic        en_i,
  input  logic [7:0]  byte_i,
  input  logic [3:0]  max_bytes_i,
  output logic [63:0] val_o,
  output logic        done_o,
  output logic        overlong_o
);
  logic [63:0] acc_q;
  logic [3:0]  cnt_q;
  logic [6:0]  sh;

  // Group n lands at bit 7n; on the 10th byte (shift 63) everything above
  // bit 0 falls off the 64-bit result.
  assign sh         = 7'(cnt_q) * 7'd7;
  assign val_o      = acc_q | ({57'd0, byte_i[6:0]} << sh);
  assign done_o     = en_i & ~byte_i[7];
  assign overlong_o = en_i & byte_i[7] & (cnt_q == max_bytes_i - 4'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (clr_i | done_o | overlong_o) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (en_i) begin
      acc_q <= val_o;
      cnt_q <= cnt_q + 4'd1;
    end
  end
endmodule

// File: rtl/protobuf_deserializer.sv
// Protobuf wire-format deserializer: turns a byte stream into one record per
// scalar field, a LEN header per length-delimited field, then one record per
// payload byte.
//   clock_clk   : clock, rising edge
//   reset_reset : async active-high reset
//   clr         : sync clear back to KEY, drops any partial record/byte
//   bus         : protobuf_deserializer_if.slave (byte in, record out)
//   err         : one-cycle pulse on a protocol error; FSM then parks in ERROR
// Build option: PROTOBUF_DESER_FIXED_EN enables I64/I32 (wire 1/5) decoding;
// without it those wire types are errors.
// Scalar/header records are registered and held in EMIT; payload bytes pass
// straight through (in_ready = out_ready) to keep one byte per cycle.
module protobuf_deserializer
  import protobuf_pkg::*;
#(
  parameter int FIELD_W = 29,
  parameter int LEN_W   = 16
) (
  input  logic                   clock_clk,
  input  logic                   reset_reset,
  input  logic                   clr,
  protobuf_deserializer_if.slave bus,
  output logic                   err
);
  state_e             state_q, state_d, ret_q, ret_d;
  logic [2:0]         kind_q, kind_d;
  logic [FIELD_W-1:0] field_q, field_d;
  logic [63:0]        value_q, value_d;
  logic [LEN_W-1:0]   len_q, len_d, rem_q, rem_d;
  logic               last_q, last_d, err_q, err_d;
`ifdef PROTOBUF_DESER_FIXED_EN
  logic [2:0]         fix_cnt_q, fix_cnt_d, fix_last_q, fix_last_d;
`endif

  logic        byte_xfer;
  logic        acc_en, acc_done, acc_ovl;
  logic [3:0]  acc_max;
  logic [63:0] acc_val;
  logic        key_bad_field, len_bad;

  // clr wins over a coincident transfer: the byte is consumed and ignored.
  assign byte_xfer = bus.in_valid & bus.in_ready & ~clr;
  assign acc_en    = byte_xfer &
                     ((state_q == KEY) | (state_q == VARINT) | (state_q == LEN));
  assign acc_max   = (state_q == KEY) ? KEY_MAX_BYTES : VARINT_MAX_BYTES;

  protobuf_varint_acc u_acc (
    .clk         (clock_clk),
    .rst         (reset_reset),
    .clr_i       (clr),
    .en_i        (acc_en),
    .byte_i      (bus.in_data),
    .max_bytes_i (acc_max),
    .val_o       (acc_val),
    .done_o      (acc_done),
    .overlong_o  (acc_ovl)
  );

  // Field number must be non-zero and fit FIELD_W; length must fit LEN_W.
  assign key_bad_field = (acc_val[63:3] == 61'd0) | (|(acc_val >> (FIELD_W + 3)));
  assign len_bad       = |(acc_val >> LEN_W);

  // Handshake and record muxing.
  always_comb begin
    bus.in_ready  = 1'b1;
    bus.out_valid = 1'b0;
    bus.out_kind  = kind_q;
    bus.out_value = value_q;
    bus.out_last  = last_q;
    case (state_q)
      EMIT: begin
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b1;
      end
      PAYLOAD: begin
        bus.in_ready  = bus.out_ready;
        bus.out_valid = bus.in_valid & ~clr;
        bus.out_kind  = KIND_PAYLOAD;
        bus.out_value = {56'd0, bus.in_data};
        bus.out_last  = (rem_q == LEN_W'(1));
      end
      default: ;
    endcase
  end

  assign bus.out_field = field_q;
  assign bus.out_len   = len_q;
  assign err           = err_q;

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ret_d   = ret_q;
    kind_d  = kind_q;
    field_d = field_q;
    value_d = value_q;
    len_d   = len_q;
    rem_d   = rem_q;
    last_d  = last_q;
    err_d   = 1'b0;
`ifdef PROTOBUF_DESER_FIXED_EN
    fix_cnt_d  = fix_cnt_q;
    fix_last_d = fix_last_q;
`endif
    case (state_q)
      KEY: begin
        if (acc_ovl) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else if (acc_done) begin
          field_d = acc_val[3 +: FIELD_W];
          if (key_bad_field) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            case (acc_val[2:0])
              WT_VARINT: state_d = VARINT;
              WT_LEN:    state_d = LEN;
`ifdef PROTOBUF_DESER_FIXED_EN
              WT_I64: begin
                state_d    = FIXED;
                fix_cnt_d  = 3'd0;
                fix_last_d = 3'd7;
                value_d    = '0;
              end
              WT_I32: begin
                state_d    = FIXED;
                fix_cnt_d  = 3'd0;
                fix_last_d = 3'd3;
                value_d    = '0;
              end
`endif
              default: begin
                err_d   = 1'b1;
                state_d = ERROR;
              end
            endcase
          end
        end
      end
      VARINT: begin
        if (acc_ovl) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else if (acc_done) begin
          kind_d  = KIND_VARINT;
          value_d = acc_val;
          len_d   = '0;
          last_d  = 1'b0;
          ret_d   = KEY;
          state_d = EMIT;
        end
      end
`ifdef PROTOBUF_DESER_FIXED_EN
      FIXED: begin
        if (byte_xfer) begin
          // value_q was zeroed at key time, so I32 leaves bits 63:32 clear.
          value_d[{fix_cnt_q, 3'b000} +: 8] = bus.in_data;
          fix_cnt_d = fix_cnt_q + 3'd1;
          if (fix_cnt_q == fix_last_q) begin
            kind_d  = (fix_last_q == 3'd7) ? KIND_I64 : KIND_I32;
            len_d   = '0;
            last_d  = 1'b0;
            ret_d   = KEY;
            state_d = EMIT;
          end
        end
      end
`endif
      LEN: begin
        if (acc_ovl) begin
          err_d   = 1'b1;
          state_d = ERROR;
        end else if (acc_done) begin
          if (len_bad) begin
            err_d   = 1'b1;
            state_d = ERROR;
          end else begin
            kind_d  = KIND_LEN;
            value_d = '0;
            len_d   = acc_val[LEN_W-1:0];
            rem_d   = acc_val[LEN_W-1:0];
            // Empty field: the header itself closes the record.
            last_d  = (acc_val[LEN_W-1:0] == '0);
            ret_d   = (acc_val[LEN_W-1:0] == '0) ? KEY : PAYLOAD;
            state_d = EMIT;
          end
        end
      end
      PAYLOAD: begin
        // in_ready tracks out_ready here, so a byte transfer is a record transfer.
        if (byte_xfer) begin
          rem_d = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = KEY;
        end
      end
      EMIT: begin
        if (bus.out_ready) state_d = ret_q;
      end
      ERROR: ;
      default: state_d = KEY;
    endcase

    if (clr) begin
      state_d = KEY;
      ret_d   = KEY;
      rem_d   = '0;
      err_d   = 1'b0;
`ifdef PROTOBUF_DESER_FIXED_EN
      fix_cnt_d = 3'd0;
`endif
    end
  end

  always_ff @(posedge clock_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state_q <= KEY;
      ret_q   <= KEY;
      kind_q  <= '0;
      field_q <= '0;
      value_q <= '0;
      len_q   <= '0;
      rem_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
`ifdef PROTOBUF_DESER_FIXED_EN
      fix_cnt_q  <= '0;
      fix_last_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      ret_q   <= ret_d;
      kind_q  <= kind_d;
      field_q <= field_d;
      value_q <= value_d;
      len_q   <= len_d;
      rem_q   <= rem_d;
      last_q  <= last_d;
      err_q   <= err_d;
`ifdef PROTOBUF_DESER_FIXED_EN
      fix_cnt_q  <= fix_cnt_d;
      fix_last_q <= fix_last_d;
`endif
    end
  end
endmodule

// File: tb/tb_protobuf_deserializer.sv
// Scoreboard bench for protobuf_deserializer: expected records are queued as
// bytes are driven; a negedge monitor collects accepted records and err pulses.
module tb_protobuf_deserializer;
  import protobuf_pkg::*;

  localparam int FW = 29;
  localparam int LW = 16;

  typedef struct packed {
    logic [2:0]    kind;
    logic [FW-1:0] field;
    logic [63:0]   value;
    logic [LW-1:0] len;
    logic          last;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic clr = 1'b0;
  logic err;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  rec_t sb[$];
  rec_t obs[$];

  protobuf_deserializer_if #(.FIELD_W(FW), .LEN_W(LW)) ifc ();

  protobuf_deserializer #(.FIELD_W(FW), .LEN_W(LW)) dut (
    .clock_clk   (clk),
    .reset_reset (rst),
    .clr         (clr),
    .bus         (ifc),
    .err         (err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (!rst && ifc.out_valid && ifc.out_ready)
      obs.push_back({ifc.out_kind, ifc.out_field, ifc.out_value, ifc.out_len, ifc.out_last});
    if (!rst && err) err_cnt++;
  end

  // LEN headers carry no value; other records carry no length.
  function automatic rec_t norm(input rec_t r);
    rec_t n = r;
    if (r.kind == KIND_LEN) n.value = '0;
    else n.len = '0;
    return n;
  endfunction

  function automatic string fmt(input rec_t r);
    return $sformatf("k=%0d f=%0d v=%h len=%0d last=%b", r.kind, r.field, r.value, r.len, r.last);
  endfunction

  function automatic void exp_rec(input logic [2:0] k, input logic [FW-1:0] f,
                                  input logic [63:0] v, input logic [LW-1:0] l, input logic last);
    sb.push_back({k, f, v, l, last});
  endfunction

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    logic rdy;
    int   t = 0;
    ifc.in_data  = b;
    ifc.in_valid = 1'b1;
    do begin
      @(negedge clk);
      rdy = ifc.in_ready;
      @(posedge clk); #1;
      t++;
    end while (!rdy && t < 200);
    ifc.in_valid = 1'b0;
    if (!rdy) begin
      n_cmp++; n_bad++;
      $display("FAIL send_timeout: byte %h not accepted, in_ready stayed %b", b, rdy);
    end
  endtask

  task automatic wait_rec(output rec_t r, output bit ok);
    int t = 0;
    while (obs.size() == 0 && t < 300) begin
      @(negedge clk); #1;
      t++;
    end
    ok = (obs.size() != 0);
    r  = ok ? obs.pop_front() : '0;
    step();
  endtask

  task automatic pulse_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_cmp++; if (ifc.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", ifc.in_ready); end
    n_cmp++; if (ifc.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", ifc.out_valid); end
    n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", err); end
    n_cmp++;
    if ({ifc.out_kind, ifc.out_field, ifc.out_value, ifc.out_len, ifc.out_last} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs: got k=%0d f=%0d v=%h len=%0d last=%b want all 0",
               ifc.out_kind, ifc.out_field, ifc.out_value, ifc.out_len, ifc.out_last);
    end
    step();
    rst = 1'b0;
    step();
  endtask

  task automatic test_varint();
    rec_t e, g; bit ok;
    exp_rec(KIND_VARINT, 29'd1, 64'd150, '0, 1'b0);
    send_byte(8'h08); send_byte(8'h96); send_byte(8'h01);
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL varint_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL varint_extra: got %0d extra records want 0", obs.size()); obs.delete(); end
  endtask

  task automatic test_len_payload();
    rec_t e, g; bit ok;
    exp_rec(KIND_LEN, 29'd2, '0, 16'd3, 1'b0);
    exp_rec(KIND_PAYLOAD, 29'd2, 64'h61, '0, 1'b0);
    exp_rec(KIND_PAYLOAD, 29'd2, 64'h62, '0, 1'b0);
    exp_rec(KIND_PAYLOAD, 29'd2, 64'h63, '0, 1'b1);
    exp_rec(KIND_LEN, 29'd3, '0, 16'd0, 1'b1);
    send_byte(8'h12); send_byte(8'h03);
    send_byte(8'h61); send_byte(8'h62); send_byte(8'h63);
    send_byte(8'h1A); send_byte(8'h00);
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL len_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL len_extra: got %0d extra records want 0", obs.size()); obs.delete(); end
  endtask

  task automatic test_back_to_back();
    rec_t e, g; bit ok;
    int t0;
    exp_rec(KIND_LEN, 29'd4, '0, 16'd4, 1'b0);
    for (int i = 0; i < 4; i++) exp_rec(KIND_PAYLOAD, 29'd4, 64'(8'hA0 + i), '0, i == 3);
    send_byte(8'h22); send_byte(8'h04); send_byte(8'hA0);
    t0 = cyc;
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3);
    n_cmp++; if (cyc - t0 != 3) begin n_bad++; $display("FAIL b2b_rate: got %0d cycles for 3 payload bytes want 3", cyc - t0); end
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL b2b_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL b2b_extra: got %0d extra records want 0", obs.size()); obs.delete(); end
  endtask

  task automatic test_overlong();
    rec_t e, g; bit ok;
    int e0 = err_cnt;
    send_byte(8'h08);
    for (int i = 0; i < 9; i++) send_byte(8'hFF);
    @(negedge clk); #1;
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL ovl_early_err: got %0d err pulses after 9 bytes want 0", err_cnt - e0); end
    step();
    send_byte(8'hFF);
    @(negedge clk); #1;
    n_cmp++; if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL ovl_err: got %0d err pulses want 1", err_cnt - e0); end
    step();
    send_byte(8'h08); send_byte(8'h01); send_byte(8'h10); send_byte(8'h02);
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL ovl_absorb: got %0d records in ERROR want 0", obs.size()); obs.delete(); end
    n_cmp++; if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL ovl_err_once: got %0d err pulses want 1", err_cnt - e0); end
    pulse_clr();
    exp_rec(KIND_VARINT, 29'd1, 64'd1, '0, 1'b0);
    send_byte(8'h08); send_byte(8'h01);
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL ovl_recover: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
  endtask

  task automatic test_errors();
    logic [7:0] seq [6][5];
    int         slen [6];
    int         e0;
    seq[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00}; slen[0] = 1; // field 0
    seq[1] = '{8'h0B, 8'h00, 8'h00, 8'h00, 8'h00}; slen[1] = 1; // wire 3
    seq[2] = '{8'h0F, 8'h00, 8'h00, 8'h00, 8'h00}; slen[2] = 1; // wire 7
    seq[3] = '{8'h0A, 8'h80, 8'h80, 8'h04, 8'h00}; slen[3] = 4; // length 65536
    seq[4] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h80}; slen[4] = 5; // 6+ byte key
    seq[5] = '{8'h80, 8'h80, 8'h80, 8'h80, 8'h10}; slen[5] = 5; // field 2^29
    for (int c = 0; c < 6; c++) begin
      e0 = err_cnt;
      for (int j = 0; j < slen[c]; j++) send_byte(seq[c][j]);
      @(negedge clk); #1;
      n_cmp++; if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL err_case%0d: got %0d err pulses want 1", c, err_cnt - e0); end
      step();
      send_byte(8'h08); send_byte(8'h01);
      repeat (3) step();
      n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL err_case%0d_absorb: got %0d records want 0", c, obs.size()); obs.delete(); end
      pulse_clr();
    end
  endtask

  task automatic test_fixed();
    rec_t e, g; bit ok;
    int e0 = err_cnt;
`ifdef PROTOBUF_DESER_FIXED_EN
    exp_rec(KIND_I32, 29'd1, 64'h0000_0000_1234_5678, '0, 1'b0);
    exp_rec(KIND_I64, 29'd2, 64'h0102_0304_0506_0708, '0, 1'b0);
    send_byte(8'h0D); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    send_byte(8'h11);
    for (int i = 8; i >= 1; i--) send_byte(8'(i));
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL fixed_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    n_cmp++; if (err_cnt != e0) begin n_bad++; $display("FAIL fixed_err: got %0d err pulses want 0", err_cnt - e0); end
`else
    send_byte(8'h0D); send_byte(8'h78); send_byte(8'h56); send_byte(8'h34); send_byte(8'h12);
    repeat (3) step();
    n_cmp++; if (err_cnt != e0 + 1) begin n_bad++; $display("FAIL fixed_err: got %0d err pulses want 1", err_cnt - e0); end
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL fixed_absorb: got %0d records want 0", obs.size()); obs.delete(); end
    pulse_clr();
    e = '0; g = '0; ok = 1'b0;
`endif
  endtask

  task automatic test_backpressure();
    rec_t e, g; bit ok;
    int hold_bad = 0;
    int rdy_bad  = 0;
    exp_rec(KIND_VARINT, 29'd1, 64'd150, '0, 1'b0);
    exp_rec(KIND_VARINT, 29'd2, 64'd5, '0, 1'b0);
    ifc.out_ready = 1'b0;
    send_byte(8'h08); send_byte(8'h96); send_byte(8'h01);
    fork
      begin
        send_byte(8'h10); send_byte(8'h05);
      end
      begin
        repeat (20) begin
          @(negedge clk);
          if (!(ifc.out_valid === 1'b1 && ifc.out_value === 64'd150 && ifc.out_field === 29'd1 &&
                ifc.out_kind === KIND_VARINT)) hold_bad++;
          if (ifc.in_ready !== 1'b0) rdy_bad++;
        end
        step();
        ifc.out_ready = 1'b1;
      end
    join
    n_cmp++; if (hold_bad != 0) begin n_bad++; $display("FAIL bp_hold: record unstable in %0d of 20 stalled cycles want 0", hold_bad); end
    n_cmp++; if (rdy_bad != 0) begin n_bad++; $display("FAIL bp_in_ready: in_ready high in %0d of 20 stalled cycles want 0", rdy_bad); end
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL bp_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL bp_extra: got %0d extra records want 0", obs.size()); obs.delete(); end
  endtask

  task automatic test_clr_drop();
    rec_t e, g; bit ok;
    exp_rec(KIND_VARINT, 29'd2, 64'd5, '0, 1'b0);
    send_byte(8'h08);
    ifc.in_data = 8'h96; ifc.in_valid = 1'b1; clr = 1'b1;
    step();
    ifc.in_valid = 1'b0; clr = 1'b0;
    send_byte(8'h10); send_byte(8'h05);
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL clr_drop_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
  endtask

  task automatic test_reset_mid();
    rec_t e, g; bit ok;
    exp_rec(KIND_LEN, 29'd2, '0, 16'd5, 1'b0);
    exp_rec(KIND_PAYLOAD, 29'd2, 64'h61, '0, 1'b0);
    exp_rec(KIND_PAYLOAD, 29'd2, 64'h62, '0, 1'b0);
    send_byte(8'h12); send_byte(8'h05); send_byte(8'h61); send_byte(8'h62);
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({ifc.out_valid, ifc.out_kind, ifc.out_field, ifc.out_value, ifc.out_len, ifc.out_last, err} !== '0 ||
        ifc.in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_mid_outputs: got v=%b k=%0d f=%0d val=%h len=%0d last=%b err=%b rdy=%b want zeros rdy=1",
               ifc.out_valid, ifc.out_kind, ifc.out_field, ifc.out_value, ifc.out_len, ifc.out_last, err, ifc.in_ready);
    end
    step();
    rst = 1'b0;
    exp_rec(KIND_VARINT, 29'd1, 64'd7, '0, 1'b0);
    step();
    send_byte(8'h08); send_byte(8'h07);
    while (sb.size() != 0) begin
      e = sb.pop_front(); wait_rec(g, ok); n_cmp++;
      if (!ok || norm(g) !== norm(e)) begin n_bad++; $display("FAIL rst_mid_rec: got %s (seen=%0b) want %s", fmt(g), ok, fmt(e)); end
    end
    repeat (4) step();
    n_cmp++; if (obs.size() != 0) begin n_bad++; $display("FAIL rst_mid_extra: got %0d extra records want 0", obs.size()); obs.delete(); end
  endtask

  initial begin
    ifc.in_data   = 8'h00;
    ifc.in_valid  = 1'b0;
    ifc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    test_varint();
    test_len_payload();
    test_back_to_back();
    test_overlong();
    test_errors();
    test_fixed();
    test_backpressure();
    test_clr_drop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, %0d compared so far", n_cmp);
    $fatal(1);
  end
endmodule

// File: doc/protobuf_deserializer.md
PROTOBUF_DESERIALIZER -- requirements
Module: protobuf_deserializer

Interface
REQ-001 SHALL have parameter FIELD_W, default 29: width of the decoded field number.
REQ-002 SHALL have parameter LEN_W, default 16: width of the length-delimited byte count.
REQ-003 SHALL have port clock_clk, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port clr, input, 1: synchronous clear; returns the FSM to KEY and drops partial state.
REQ-006 SHALL have ports in_data (input, 8), in_valid (input, 1) and in_ready (output, 1): the serialized byte stream; a byte transfers when in_valid and in_ready are both high.
REQ-007 SHALL have ports out_valid (output, 1) and out_ready (input, 1): the decoded-record handshake; a record transfers when both are high.
REQ-008 SHALL have port out_kind, output, 3: 0 VARINT, 1 I64, 2 LEN header, 3 PAYLOAD byte, 5 I32.
REQ-009 SHALL have ports out_field (output, FIELD_W), out_value (output, 64), out_len (output, LEN_W) and out_last (output, 1).
REQ-010 SHALL have port err, output, 1: one-cycle pulse when an error is detected.

Function
REQ-011 SHALL implement FSM states KEY, VARINT, FIXED, LEN, PAYLOAD, EMIT and ERROR.
REQ-012 KEY SHALL accumulate key bytes, LSB group first, 7 bits per byte; the byte with MSB=0 terminates the key.
REQ-013 Key decode SHALL be field=key>>3 and wire=key[2:0]; wire 0->VARINT, 1->FIXED(8), 2->LEN, 5->FIXED(4).
REQ-014 VARINT SHALL compute value |= (byte&0x7F)<<7n; on the 10th byte only bit 0 is kept.
REQ-015 FIXED SHALL collect bytes little-endian; unused upper bits of out_value SHALL be 0 for I32.
REQ-016 LEN SHALL decode the length varint, then emit a LEN header record with out_len=length.
REQ-017 PAYLOAD SHALL emit one record per byte: out_value[7:0]=byte and upper bits 0.
REQ-018 out_last SHALL be 1 on the final payload byte, and on the LEN header when length=0, which then returns to KEY.
REQ-019 EMIT SHALL hold out_valid and all out_* stable until out_ready; in_ready SHALL be 0 while out_valid=1 and unaccepted.
REQ-020 out_valid SHALL rise the cycle after the terminating byte is accepted; out_field SHALL be valid on every record.
REQ-021 SHALL sustain one byte per cycle in PAYLOAD when out_ready=1, i.e. a combinational pass-through with in_ready=out_ready.
REQ-022 Errors SHALL be: key longer than 5 bytes, value or length varint longer than 10 bytes, field=0, field exceeding FIELD_W bits, wire type 3/4/6/7, or length exceeding LEN_W bits.
REQ-023 On an error, err SHALL pulse and the FSM SHALL enter ERROR, where in_ready=1, bytes are discarded, no records are emitted, and only clr or reset exits.
REQ-024 If clr and an input transfer coincide, clr SHALL win and the byte SHALL be dropped.

Reset
REQ-025 Reset SHALL force state=KEY, in_ready=1, out_valid=0, err=0, out_last=0, out_kind=0, out_field=0, out_value=0, out_len=0, and clear the accumulators and byte counters.
REQ-026 Reset asserted mid-record SHALL abandon the record with no partial output after release.

Configuration
REQ-027 Macro PROTOBUF_DESER_FIXED_EN defined: wire types 1 and 5 SHALL be decoded per REQ-015.
REQ-028 Macro PROTOBUF_DESER_FIXED_EN undefined: the FIXED state SHALL be absent and wire types 1 and 5 SHALL be errors per REQ-023.

Structure
REQ-029 Package protobuf_pkg SHALL hold the wire-type constants, the out_kind encodings, the FSM state enum and the max varint byte counts (5 and 10).
REQ-030 Sub-module protobuf_varint_acc SHALL hold the shared 7-bit-group accumulator, byte counter and overlong detect, reused by the KEY, VARINT and LEN states.

Verification
REQ-031 Input 08 96 01 -> one record: field=1, kind=VARINT, value=150, err=0.
REQ-032 Input 12 03 61 62 63 -> LEN header (field=2, len=3), then PAYLOAD 0x61, 0x62, 0x63 with out_last on 0x63; input 1A 00 -> header field=3, len=0, out_last=1.
REQ-033 Input 08 followed by ten FF bytes -> err pulse on the 10th FF, state ERROR, further bytes absorbed with no output until clr, after which 08 01 decodes to value 1.
REQ-034 Input 0D 78 56 34 12 -> with the macro: field=1, kind=I32, value=0x12345678; without the macro: err.
REQ-035 Input 08 96 01 10 05 with out_ready=0 for 20 cycles -> first record held stable, in_ready=0, no loss; then field=2, value=5.
REQ-036 Reset asserted after 12 05 61 62 -> all outputs reset; after release, 08 07 decodes to field=1, value=7.
